// File: rtl/segments_array_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
//   Shared definitions for the Simon Says game blocks.
//   - NUM_SEG  : number of colour slots in a sequence
//   - COLOUR_W : width of one colour code
//   - colour_t : one colour code. The encoding is opaque to the storage logic.
//   - ptr_t    : write pointer. It is wide enough to hold NUM_SEG, the "full" value.
// ----------------------------------------------------------------------------
package game_pkg;

    localparam int NUM_SEG  = 33;
    localparam int COLOUR_W = 2;
    localparam int PTR_W    = 6;

    typedef logic [COLOUR_W-1:0] colour_t;
    typedef logic [PTR_W-1:0]    ptr_t;

    // Colour codes. Only the game FSM and the display logic give them meaning.
    localparam colour_t COLOUR_0 = 2'b00;
    localparam colour_t COLOUR_1 = 2'b01;
    localparam colour_t COLOUR_2 = 2'b10;
    localparam colour_t COLOUR_3 = 2'b11;

    // The pointer value reached once every slot has been written.
    localparam ptr_t SEG_FULL = ptr_t'(NUM_SEG);

endpackage

// File: rtl/segments_array_if.sv
// ----------------------------------------------------------------------------
// fsm_sig
//   Control strobes driven by the game FSM to the blocks around it.
//   - load_colour : append new_colour to the stored sequence on this clock
//   Modports:
//   - master : the game FSM, which drives the strobes
//   - slave  : a consumer such as segments_array, which only reads them
// ----------------------------------------------------------------------------
interface fsm_sig;
    import game_pkg::*;

    logic load_colour;

    modport master (output load_colour);
    modport slave  (input  load_colour);

endinterface

// File: rtl/segments_array.sv
// ----------------------------------------------------------------------------
// segments_array
//   Holds the Simon Says colour sequence. Each load strobe appends one colour
//   code. The whole array is presented in parallel to the playback and compare
//   logic.
//
//   Ports:
//   - clk        : system clock, rising-edge active
//   - reset      : asynchronous, active-high. Clears every slot and the pointer.
//   - new_colour : colour code that is appended when sigs.load_colour is high
//   - segment    : stored colours. segment[k] is the k-th colour loaded.
//                  Slots that have not been written read 0.
//   - sigs       : game FSM control bundle. Only load_colour is used here.
//
//   Once all NUM_SEG slots are written, further loads are dropped. The pointer
//   never wraps, so slot 0 is never overwritten. The sequence length lives in
//   the FSM. It cannot be recovered from the slot contents, because 0 is a
//   valid colour code.
// ----------------------------------------------------------------------------
module segments_array
    import game_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  colour_t                  new_colour,
    output colour_t [NUM_SEG-1:0]    segment,
    fsm_sig.slave                    sigs
);

    colour_t [NUM_SEG-1:0] segment_q;
    colour_t [NUM_SEG-1:0] segment_d;
    ptr_t                  wr_ptr_q;
    ptr_t                  wr_ptr_d;

    logic                  do_load;

    // Loads are accepted only while a free slot remains.
    assign do_load = sigs.load_colour && (wr_ptr_q < SEG_FULL);

    always_comb begin
        segment_d = segment_q;
        wr_ptr_d  = wr_ptr_q;
        if (do_load) begin
            // Only the addressed slot changes. All other slots keep their value.
            segment_d[wr_ptr_q] = new_colour;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
    end

    // Reset takes priority over a load on the same edge, so nothing is stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segment_q <= '0;
            wr_ptr_q  <= '0;
        end else begin
            segment_q <= segment_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // segment comes straight from the registers. There is no combinational
    // path from any input to this output.
    assign segment = segment_q;

endmodule

// File: tb/tb_segments_array.sv
// ----------------------------------------------------------------------------
// tb_segments_array
//   Self-checking bench for segments_array. It covers reset, a table of
//   directed loads and holds, reset asserted in the middle of a cycle, the
//   fill-to-full boundary and a random load stream compared against a
//   queue-based model.
// ----------------------------------------------------------------------------
module tb_segments_array;
    import game_pkg::*;

    logic                   clk;
    logic                   reset;
    logic [1:0]             new_colour;
    logic [32:0][1:0]       segment;

    fsm_sig sig_if ();

    segments_array dut (
        .clk        (clk),
        .reset      (reset),
        .new_colour (new_colour),
        .segment    (segment),
        .sigs       (sig_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic [1:0] colour;
        int         exp_idx;    // slot to inspect after the edge
        logic [1:0] exp_val;    // required value of that slot
        int         zero_from;  // every slot >= this index must read 00
    } vec_t;

    vec_t       vecs [7];
    int         n_vec;
    int         n_bad;
    logic [1:0] model_q [$];

    // Advance one clock edge. The bench samples 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input int idx,
                             input logic [1:0] val, input int zf);
        logic ok;
        ok = (segment[idx] === val);
        for (int k = zf; k < NUM_SEG; k++)
            if (segment[k] !== 2'b00) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: segment=%h, required slot[%0d]=%b and slots>=%0d zero",
                     name, segment, idx, val, zf);
        end
    endtask

    task automatic check_full(input string name, input logic [32:0][1:0] exp);
        n_vec++;
        if (segment !== exp) begin
            n_bad++;
            $display("FAIL %s: segment=%h required=%h", name, segment, exp);
        end
    endtask

    initial begin
        logic [32:0][1:0] exp;
        n_vec = 0;
        n_bad = 0;

        // Directed table. It starts from an empty array.
        vecs[0] = '{1'b1, 2'b01, 0, 2'b01, 1};
        vecs[1] = '{1'b1, 2'b10, 1, 2'b10, 2};
        vecs[2] = '{1'b1, 2'b11, 2, 2'b11, 3};
        vecs[3] = '{1'b0, 2'b11, 2, 2'b11, 3};   // hold: new_colour is ignored
        vecs[4] = '{1'b0, 2'b10, 0, 2'b01, 3};   // hold again with other data
        vecs[5] = '{1'b1, 2'b00, 1, 2'b10, 4};   // slot 3 receives 00
        vecs[6] = '{1'b1, 2'b01, 4, 2'b01, 5};   // the pointer did advance past slot 3

        // Reset
        reset                 = 1'b1;
        new_colour            = 2'b00;
        sig_if.load_colour    = 1'b0;
        step();
        check_full("reset_clear", '0);
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            sig_if.load_colour = vecs[i].load;
            new_colour         = vecs[i].colour;
            step();
            check_vec($sformatf("table_%0d", i), vecs[i].exp_idx,
                      vecs[i].exp_val, vecs[i].zero_from);
        end
        exp = '0;
        exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b11; exp[3] = 2'b00; exp[4] = 2'b01;
        sig_if.load_colour = 1'b0;
        step();
        check_full("table_final", exp);

        // Reset asserted in the middle of a cycle while a load is pending
        sig_if.load_colour = 1'b1;
        new_colour         = 2'b11;
        #2 reset = 1'b1;
        #1;
        check_full("async_clear", '0);
        step();
        check_full("reset_beats_load", '0);
        reset              = 1'b0;
        new_colour         = 2'b10;
        step();
        exp = '0;
        exp[0] = 2'b10;
        check_full("load_after_release", exp);
        sig_if.load_colour = 1'b0;

        // Fill to full: 35 loads of alternating 01/10
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 35; i++) begin
            sig_if.load_colour = 1'b1;
            new_colour         = (i % 2 == 0) ? 2'b01 : 2'b10;
            step();
            if (i < NUM_SEG) begin
                check_vec($sformatf("fill_%0d", i), i, new_colour, i + 1);
            end else begin
                for (int k = 0; k < NUM_SEG; k++)
                    exp[k] = (k % 2 == 0) ? 2'b01 : 2'b10;
                check_full($sformatf("full_ignore_%0d", i), exp);
            end
        end
        sig_if.load_colour = 1'b0;
        step();
        check_vec("slot0_kept", 0, 2'b01, NUM_SEG);

        // Random stream compared against a queue model
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_q.delete();
        for (int c = 0; c < 200; c++) begin
            sig_if.load_colour = 1'($urandom_range(0, 1));
            new_colour         = 2'($urandom_range(0, 3));
            step();
            if (sig_if.load_colour && model_q.size() < NUM_SEG)
                model_q.push_back(new_colour);
            for (int k = 0; k < NUM_SEG; k++)
                exp[k] = (k < model_q.size()) ? model_q[k] : 2'b00;
            check_full($sformatf("random_%0d", c), exp);
        end
        sig_if.load_colour = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
